// File: rtl/fetch_stage.sv
// fetch_stage: PC, single-outstanding imem fetch FSM, fetch FIFO
// and the IF/ID pipeline register feeding decode.
module fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 2,
  parameter logic [31:0] NOP      = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        stall,
  input  logic        flush,
  input  logic        branch,
  input  logic [31:0] branch_addr,
  output logic [31:0] pc_o,
  output logic [31:0] inst_o,
  output logic        inst_valid_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_C = (AW+1)'(DEPTH);

  typedef enum logic [1:0] {
    IDLE, REQ, WAIT, DROP
  } state_t;

  state_t      state, state_n;
  logic [31:0] pc, pc_n;
  logic [31:0] req_addr, req_addr_n;
  logic        stale, stale_n;
  logic        redir, push, pop;

  logic [31:0] fifo_pc   [DEPTH];
  logic [31:0] fifo_inst [DEPTH];
  logic [AW-1:0] wptr, rptr;
  logic [AW:0]   count;

  // operands may be stale while decode stalls
  assign redir = branch & ~stall;
  assign pop   = ~redir & ~flush & ~stall
               & (count != '0);

  assign imem_req_valid = (state == REQ);
  assign imem_addr      = req_addr;

  always_comb begin
    state_n    = state;
    pc_n       = pc;
    req_addr_n = req_addr;
    stale_n    = stale;
    push       = 1'b0;
    unique case (state)
      IDLE: begin
        if (!redir && count < DEPTH_C) begin
          req_addr_n = pc;
          state_n    = REQ;
        end
      end
      REQ: begin
        if (imem_req_ready) begin
          state_n = (stale | redir) ? DROP : WAIT;
          if (!stale && !redir)
            pc_n = req_addr + 32'd4;
        end else if (redir) begin
          stale_n = 1'b1;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          push    = ~redir;
          state_n = IDLE;
        end else if (redir) begin
          state_n = DROP;
        end
      end
      DROP: begin
        if (imem_rsp_valid) begin
          stale_n = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    if (redir)
      pc_n = branch_addr;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      req_addr <= RESET_PC;
      stale    <= 1'b0;
    end else begin
      state    <= state_n;
      pc       <= pc_n;
      req_addr <= req_addr_n;
      stale    <= stale_n;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else if (redir) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push)
        wptr <= wptr + AW'(1);
      if (pop)
        rptr <= rptr + AW'(1);
      if (push && !pop)
        count <= count + (AW+1)'(1);
      else if (pop && !push)
        count <= count - (AW+1)'(1);
    end
  end

  // storage needs no reset; count guards every read
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wptr]   <= req_addr;
      fifo_inst[wptr] <= imem_rsp_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_o         <= 32'd0;
      inst_o       <= NOP;
      inst_valid_o <= 1'b0;
    end else if (redir || flush) begin
      pc_o         <= 32'd0;
      inst_o       <= NOP;
      inst_valid_o <= 1'b0;
    end else if (!stall) begin
      if (pop) begin
        pc_o         <= fifo_pc[rptr];
        inst_o       <= fifo_inst[rptr];
        inst_valid_o <= 1'b1;
      end else begin
        pc_o         <= 32'd0;
        inst_o       <= NOP;
        inst_valid_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: memory model plus IF/ID scoreboard
// for fetch_stage.
module tb_fetch_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam int          DEPTH    = 2;
  localparam logic [64:0] BUBBLE   = {1'b0, 32'd0, NOP};

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'd0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        branch = 1'b0;
  logic [31:0] branch_addr = 32'd0;
  logic [31:0] pc_o;
  logic [31:0] inst_o;
  logic        inst_valid_o;

  fetch_stage #(
    .RESET_PC(RESET_PC),
    .DEPTH(DEPTH),
    .NOP(NOP)
  ) dut (
    .clk(clk),
    .rst(rst),
    .imem_req_valid(imem_req_valid),
    .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr),
    .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data),
    .stall(stall),
    .flush(flush),
    .branch(branch),
    .branch_addr(branch_addr),
    .pc_o(pc_o),
    .inst_o(inst_o),
    .inst_valid_o(inst_valid_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t sb[$];
  int   vec = 0;
  int   errs = 0;

  // stimulus controls
  logic        c_stall = 1'b0;
  logic        c_flush = 1'b0;
  logic        c_branch = 1'b0;
  logic [31:0] c_baddr = 32'd0;
  logic        c_ready = 1'b1;
  int          lat = 1;

  // model state
  logic [64:0] exp_ifid = BUBBLE;
  logic [31:0] fetch_pc = RESET_PC;
  logic [31:0] held_addr = 32'd0;
  int          epoch = 0;
  int          req_tag = 0;
  bit          req_pending = 0;
  bit          just_acc = 0;
  bit          pend = 0;
  int          pend_tag = 0;
  logic [31:0] pend_addr = 32'd0;
  int          pend_due = 0;
  int          cyc = 0;

  function automatic logic [31:0] mem(input logic [31:0] a);
    return 32'hC000_0000 ^ (a * 32'd7);
  endfunction

  task automatic check(input string tag,
                       input logic [64:0] got,
                       input logic [64:0] exp);
    vec++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    bit          redir;
    bit          acc;
    bit          dlv;
    int          dtag;
    logic [31:0] daddr;
    ent_t        e;
    @(negedge clk);
    cyc++;
    just_acc = 0;
    check("ifid", {inst_valid_o, pc_o, inst_o}, exp_ifid);
    if (sb.size() >= DEPTH)
      check("gate", {64'd0, imem_req_valid}, 65'd0);

    stall       = c_stall;
    flush       = c_flush;
    branch      = c_branch;
    branch_addr = c_baddr;
    redir       = c_branch & ~c_stall;

    if (imem_req_valid) begin
      if (!req_pending) begin
        req_tag   = epoch;
        held_addr = imem_addr;
      end else begin
        check("addr_hold", {33'd0, imem_addr},
              {33'd0, held_addr});
      end
    end

    if (redir) begin
      epoch++;
      sb.delete();
      fetch_pc = c_baddr;
    end

    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    dlv   = 0;
    dtag  = 0;
    daddr = 32'd0;
    if (pend && cyc >= pend_due) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem(pend_addr);
      dlv   = 1;
      dtag  = pend_tag;
      daddr = pend_addr;
      pend  = 0;
    end

    imem_req_ready = c_ready;
    acc = imem_req_valid & c_ready;
    if (imem_req_valid) begin
      if (acc) begin
        if (req_tag == epoch) begin
          check("acc_addr", {33'd0, imem_addr},
                {33'd0, fetch_pc});
          fetch_pc = fetch_pc + 32'd4;
        end
        pend        = 1;
        pend_tag    = req_tag;
        pend_addr   = imem_addr;
        pend_due    = cyc + lat;
        req_pending = 0;
        just_acc    = 1;
      end else begin
        req_pending = 1;
      end
    end

    if (redir || c_flush) begin
      exp_ifid = BUBBLE;
    end else if (!c_stall) begin
      if (sb.size() != 0) begin
        e = sb.pop_front();
        exp_ifid = {1'b1, e.pc, e.inst};
      end else begin
        exp_ifid = BUBBLE;
      end
    end
    if (dlv && dtag == epoch)
      sb.push_back({daddr, mem(daddr)});
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++)
      cycle();
  endtask

  task automatic run_until_acc();
    int n = 0;
    just_acc = 0;
    while (!just_acc && n < 20) begin
      cycle();
      n++;
    end
    check("wait_acc", {64'd0, just_acc}, 65'd1);
  endtask

  task automatic run_until_req();
    int n = 0;
    while (!req_pending && n < 20) begin
      cycle();
      n++;
    end
    check("wait_req", {64'd0, req_pending}, 65'd1);
  endtask

  initial begin
    #12;
    check("rst_ifid", {inst_valid_o, pc_o, inst_o}, BUBBLE);
    check("rst_req", {32'd0, imem_req_valid, imem_addr},
          {33'd0, RESET_PC});
    @(negedge clk);
    rst = 1'b1;

    // straight-line fetch, 1-cycle memory
    run(30);

    // stall long enough to fill the FIFO
    c_stall = 1'b1;
    run(10);
    check("full_noreq", {64'd0, imem_req_valid}, 65'd0);
    c_stall = 1'b0;
    run(10);

    // redirect while a response is in flight
    lat = 3;
    run_until_acc();
    c_branch = 1'b1;
    c_baddr  = 32'h0000_0100;
    cycle();
    c_branch = 1'b0;
    lat = 1;
    run(20);

    // redirect while the request is held off
    c_ready = 1'b0;
    run_until_req();
    c_branch = 1'b1;
    c_baddr  = 32'h0000_0200;
    cycle();
    c_branch = 1'b0;
    run(2);
    c_ready = 1'b1;
    run(20);

    // branch under stall is ignored; flush under stall
    c_stall  = 1'b1;
    c_branch = 1'b1;
    c_baddr  = 32'h0000_0300;
    run(3);
    c_branch = 1'b0;
    c_flush  = 1'b1;
    run(2);
    c_stall = 1'b0;
    run(1);
    c_flush = 1'b0;
    run(15);

    // asynchronous reset during WAIT
    lat = 3;
    run_until_acc();
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("arst_ifid", {inst_valid_o, pc_o, inst_o}, BUBBLE);
    check("arst_req", {32'd0, imem_req_valid, imem_addr},
          {33'd0, RESET_PC});
    sb.delete();
    epoch++;
    pend        = 0;
    req_pending = 0;
    fetch_pc    = RESET_PC;
    exp_ifid    = BUBBLE;
    lat         = 1;
    @(negedge clk);
    rst = 1'b1;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hDEAD_BEEF;
    run(25);

    $display("== %0d vectors applied, %0d miscompares ==",
             vec, errs);
    $finish;
  end

endmodule
